// File: rtl/axi_pkg.sv
// AXI shared constants for the write-path blocks.
// Burst and response encodings plus a burst legality helper.
package axi_pkg;

  localparam int ID_W_DEF   = 4;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 64;
  localparam int LEN_W_DEF  = 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic RESP_OKAY = 1'b0;
  localparam logic RESP_ERR  = 1'b1;

  function automatic logic burst_ok(input logic [1:0] b);
    return (b == BURST_FIXED) || (b == BURST_INCR);
  endfunction

endpackage

// File: rtl/axi_wr_addr_gen.sv
// Burst address and beat counter for the AXI write slave.
// Loads on AW accept, steps per accepted beat, flags the last beat.
module axi_wr_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [2:0]        i_size,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic [2:0]        r_size;
  logic [1:0]        r_burst;
  logic [ADDR_W-1:0] w_one;
  logic [ADDR_W-1:0] w_inc;

  assign w_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_inc  = w_one << r_size;
  assign o_addr = r_addr;
  assign o_last = (r_cnt == r_len);

  // Capture burst on AW accept, then advance once per accepted beat
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
    end else if (i_load) begin
      r_addr  <= i_addr;
      r_cnt   <= '0;
      r_len   <= i_len;
      r_size  <= i_size;
      r_burst <= i_burst;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_burst != BURST_FIXED)
        r_addr <= r_addr + w_inc;
    end
  end

endmodule

// File: rtl/axi_wr_slave.sv
// AXI write slave: one burst at a time onto a native write port.
// Illegal bursts are drained and answered with an error response.
module axi_wr_slave
  import axi_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [LEN_W-1:0]    awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic                bresp,
  output logic                bvalid,
  input  logic                bready,
  output logic                mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RESP
  } state_e;

  localparam logic [2:0] SIZE_MAX = 3'($clog2(DATA_W/8));

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_awready;
  logic              r_bvalid;
  logic              r_err;
  logic [ID_W-1:0]   r_id;
  logic              w_aw_hs;
  logic              w_cap_err;
  logic              w_wready;
  logic              w_mem_wen;
  logic              w_beat;
  logic              w_last;
  logic              w_wlast_bad;
  logic [ADDR_W-1:0] w_addr;

  assign w_aw_hs     = awvalid && r_awready;
  assign w_cap_err   = !burst_ok(awburst) || (awsize > SIZE_MAX);
  assign w_wlast_bad = w_beat && (wlast != w_last);

  axi_wr_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_load  (w_aw_hs),
    .i_step  (w_beat),
    .i_addr  (awaddr),
    .i_len   (awlen),
    .i_size  (awsize),
    .i_burst (awburst),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  // Next state and per-cycle handshake/native-port decode
  always_comb begin
    w_state_nxt = r_state;
    w_wready    = 1'b0;
    w_mem_wen   = 1'b0;
    w_beat      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_aw_hs)
          w_state_nxt = DATA;
      end
      DATA: begin
        w_wready  = r_err ? 1'b1 : mem_ready;
        w_mem_wen = !r_err && wvalid && mem_ready;
        w_beat    = wvalid && w_wready;
        if (w_beat && w_last)
          w_state_nxt = RESP;
      end
      RESP: begin
        if (bready)
          w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State plus registered awready/bvalid and the burst error flag
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state   <= IDLE;
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_id      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_awready <= (w_state_nxt == IDLE);
      r_bvalid  <= (w_state_nxt == RESP);
      if (w_aw_hs) begin
        r_id  <= awid;
        r_err <= w_cap_err;
      end else if (w_wlast_bad) begin
        r_err <= RESP_ERR;
      end else if (r_state == RESP && bready) begin
        r_err <= RESP_OKAY;
      end
    end
  end

  assign awready   = r_awready;
  assign wready    = w_wready;
  assign bvalid    = r_bvalid;
  assign bid       = r_bvalid ? r_id : '0;
  assign bresp     = r_bvalid ? r_err : RESP_OKAY;
  assign mem_wen   = w_mem_wen;
  assign mem_addr  = w_mem_wen ? w_addr : '0;
  assign mem_wdata = w_mem_wen ? wdata : '0;
  assign mem_wstrb = w_mem_wen ? wstrb : '0;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed bench for axi_wr_slave.
// Monitors native writes and B handshakes, checks with assertions.
module tb_axi_wr_slave;
  import axi_pkg::*;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 8;

  logic              aclk;
  logic              areset;
  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic              bresp;
  logic              bvalid;
  logic              bready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [7:0]        mem_wstrb;
  logic              mem_ready;

  int n_pass = 0;
  int n_fail = 0;
  int n_chk  = 0;

  logic [ADDR_W-1:0] wq_a[$];
  logic [DATA_W-1:0] wq_d[$];
  int nbeats = 0;
  int bcnt   = 0;

  axi_wr_slave #(
    .ID_W   (ID_W),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) dut (
    .aclk      (aclk),
    .areset    (areset),
    .awid      (awid),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awsize    (awsize),
    .awburst   (awburst),
    .awvalid   (awvalid),
    .awready   (awready),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .wlast     (wlast),
    .wvalid    (wvalid),
    .wready    (wready),
    .bid       (bid),
    .bresp     (bresp),
    .bvalid    (bvalid),
    .bready    (bready),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(negedge aclk) begin
    if (mem_wen) begin
      wq_a.push_back(mem_addr);
      wq_d.push_back(mem_wdata);
    end
    if (wvalid && wready) nbeats++;
    if (bvalid && bready) bcnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic aw(input logic [3:0] id, input logic [31:0] a,
                    input logic [7:0] l, input logic [2:0] s,
                    input logic [1:0] b);
    logic ok;
    int   k;
    awid = id; awaddr = a; awlen = l; awsize = s; awburst = b;
    awvalid = 1'b1;
    ok = 1'b0;
    k  = 0;
    while (!ok && k < 50) begin
      #1;
      ok = awready;
      @(posedge aclk); #1;
      k++;
    end
    awvalid = 1'b0;
    chk("aw_accept", 64'(ok), 64'd1);
  endtask

  task automatic wbeats(input int n, input int lastpos,
                        input logic [63:0] d0,
                        input int stall_at, input int stall_n);
    logic acc;
    int   k;
    for (int i = 0; i < n; i++) begin
      wdata  = d0 + 64'(i);
      wstrb  = 8'hFF;
      wlast  = (i == lastpos);
      wvalid = 1'b1;
      if (i == stall_at) begin
        mem_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          #1;
          chk("stall_wready", 64'(wready), 64'd0);
          chk("stall_wen", 64'(mem_wen), 64'd0);
          @(posedge aclk); #1;
        end
        mem_ready = 1'b1;
      end
      acc = 1'b0;
      k   = 0;
      while (!acc && k < 50) begin
        #1;
        acc = wready;
        @(posedge aclk); #1;
        k++;
      end
      chk("w_accept", 64'(acc), 64'd1);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic bchk(input logic [3:0] id, input logic r, input int hold);
    chk("bvalid_next", 64'(bvalid), 64'd1);
    chk("bid", 64'(bid), 64'(id));
    chk("bresp", 64'(bresp), 64'(r));
    for (int h = 0; h < hold; h++) begin
      @(posedge aclk); #1;
      chk("hold_bvalid", 64'(bvalid), 64'd1);
      chk("hold_bid", 64'(bid), 64'(id));
      chk("hold_bresp", 64'(bresp), 64'(r));
      chk("hold_awready", 64'(awready), 64'd0);
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    chk("b_done", 64'(bvalid), 64'd0);
    chk("aw_reopen", 64'(awready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q0;
    int n0;
    int b0;
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0;
    mem_ready = 1'b1;

    repeat (2) @(posedge aclk);
    #1;
    chk("rst_awready", 64'(awready), 64'd0);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_bid", 64'(bid), 64'd0);
    chk("rst_bresp", 64'(bresp), 64'd0);
    chk("rst_mem_wen", 64'(mem_wen), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    areset = 1'b0;
    #1;
    chk("awready_pre", 64'(awready), 64'd0);
    @(posedge aclk); #1;
    chk("awready_up", 64'(awready), 64'd1);

    // early W beat stalls without an AW
    wvalid = 1'b1;
    #1;
    chk("w_before_aw", 64'(wready), 64'd0);
    wvalid = 1'b0;

    // INCR 4 beats of 8 bytes
    q0 = wq_a.size();
    aw(4'h1, 32'h100, 8'd3, 3'd3, BURST_INCR);
    wbeats(4, 3, 64'hA000, -1, 0);
    chk("incr_n", 64'(wq_a.size() - q0), 64'd4);
    chk("incr_a0", 64'(wq_a[q0]), 64'h100);
    chk("incr_a1", 64'(wq_a[q0+1]), 64'h108);
    chk("incr_a2", 64'(wq_a[q0+2]), 64'h110);
    chk("incr_a3", 64'(wq_a[q0+3]), 64'h118);
    chk("incr_d3", wq_d[q0+3], 64'hA003);
    bchk(4'h1, 1'b0, 0);

    // FIXED 3 beats
    q0 = wq_a.size();
    aw(4'h2, 32'h40, 8'd2, 3'd3, BURST_FIXED);
    wbeats(3, 2, 64'hB000, -1, 0);
    chk("fixed_n", 64'(wq_a.size() - q0), 64'd3);
    chk("fixed_a0", 64'(wq_a[q0]), 64'h40);
    chk("fixed_a1", 64'(wq_a[q0+1]), 64'h40);
    chk("fixed_a2", 64'(wq_a[q0+2]), 64'h40);
    bchk(4'h2, 1'b0, 0);

    // INCR 2 beats, native port stalls 2 cycles before beat 1
    q0 = wq_a.size();
    aw(4'h7, 32'h200, 8'd1, 3'd3, BURST_INCR);
    wbeats(2, 1, 64'hC000, 1, 2);
    chk("stall_n", 64'(wq_a.size() - q0), 64'd2);
    chk("stall_a0", 64'(wq_a[q0]), 64'h200);
    chk("stall_a1", 64'(wq_a[q0+1]), 64'h208);
    chk("stall_d0", wq_d[q0], 64'hC000);
    chk("stall_d1", wq_d[q0+1], 64'hC001);
    bchk(4'h7, 1'b0, 0);

    // WRAP is drained with wready even while mem_ready is low
    q0 = wq_a.size();
    n0 = nbeats;
    mem_ready = 1'b0;
    aw(4'h3, 32'h300, 8'd3, 3'd3, BURST_WRAP);
    wbeats(4, 3, 64'hD000, -1, 0);
    chk("wrap_beats", 64'(nbeats - n0), 64'd4);
    chk("wrap_nowen", 64'(wq_a.size() - q0), 64'd0);
    bchk(4'h3, 1'b1, 0);
    mem_ready = 1'b1;

    // oversize beat is an error
    q0 = wq_a.size();
    aw(4'h9, 32'h0, 8'd0, 3'd4, BURST_INCR);
    wbeats(1, 0, 64'hE000, -1, 0);
    chk("size_nowen", 64'(wq_a.size() - q0), 64'd0);
    bchk(4'h9, 1'b1, 0);

    // early wlast on second beat, length still 4
    n0 = nbeats;
    aw(4'h4, 32'h500, 8'd3, 3'd3, BURST_INCR);
    wbeats(4, 1, 64'hF000, -1, 0);
    chk("early_last_beats", 64'(nbeats - n0), 64'd4);
    bchk(4'h4, 1'b1, 0);

    // missing wlast on final beat
    aw(4'h5, 32'h600, 8'd1, 3'd3, BURST_INCR);
    wbeats(2, 7, 64'h1000, -1, 0);
    bchk(4'h5, 1'b1, 0);

    // bready held low five cycles
    aw(4'hA, 32'h700, 8'd0, 3'd3, BURST_INCR);
    wbeats(1, 0, 64'h2000, -1, 0);
    bchk(4'hA, 1'b0, 5);

    // reset mid-burst after one beat
    q0 = wq_a.size();
    b0 = bcnt;
    aw(4'h6, 32'h800, 8'd3, 3'd3, BURST_INCR);
    wbeats(1, 3, 64'h3000, -1, 0);
    wdata  = 64'h3001;
    wstrb  = 8'hFF;
    wvalid = 1'b1;
    areset = 1'b1;
    #1;
    chk("abort_awready", 64'(awready), 64'd0);
    chk("abort_wready", 64'(wready), 64'd0);
    chk("abort_wen", 64'(mem_wen), 64'd0);
    chk("abort_addr", 64'(mem_addr), 64'd0);
    chk("abort_wdata", mem_wdata, 64'd0);
    chk("abort_bvalid", 64'(bvalid), 64'd0);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    areset = 1'b0;
    wvalid = 1'b0;
    #1;
    chk("abort_aw_pre", 64'(awready), 64'd0);
    @(posedge aclk); #1;
    chk("abort_aw_up", 64'(awready), 64'd1);
    repeat (3) @(posedge aclk);
    #1;
    chk("abort_nob", 64'(bcnt - b0), 64'd0);
    chk("abort_bvalid2", 64'(bvalid), 64'd0);
    chk("abort_writes", 64'(wq_a.size() - q0), 64'd1);

    // clean burst after abort
    q0 = wq_a.size();
    aw(4'hB, 32'h0, 8'd0, 3'd3, BURST_INCR);
    wbeats(1, 0, 64'h4000, -1, 0);
    chk("post_n", 64'(wq_a.size() - q0), 64'd1);
    chk("post_a0", 64'(wq_a[q0]), 64'h0);
    bchk(4'hB, 1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
